// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a valid/ready handshake, pass-through tag and flush abort.
module rv_muldiv #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   mb_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    logic              a_sgn, b_sgn, sa, sb, neg_d, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN-1:0]   div_diff, quo, rem, final_res;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod_fix;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

    // Operand decode at accept: magnitudes, result sign and the special-case bypass.
    always_comb begin
        a_sgn    = ~in_op[2] ? (in_op[1:0] != 2'd3) : ~in_op[0];
        b_sgn    = ~in_op[2] ? ~in_op[1] : ~in_op[0];
        sa       = a_sgn & in_a[XLEN-1];
        sb       = b_sgn & in_b[XLEN-1];
        mag_a    = sa ? -in_a : in_a;
        mag_b    = sb ? -in_b : in_b;
        neg_d    = (in_op[2] & in_op[1]) ? sa : (sa ^ sb);
        div_zero = in_op[2] && (in_b == '0);
        div_ovf  = in_op[2] && !in_op[0] && (in_a == MinNeg) && (in_b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = in_op[1] ? in_a : '1;
        end else if (div_ovf) begin
            special_res = in_op[1] ? '0 : in_a;
        end
    end

    // One iteration step; acc holds {hi, lo} = {partial product, multiplier}
    // or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, mb_q});
        div_diff = div_sh[XLEN-1:0] - mb_q;
        div_nxt  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                          : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quo      = acc_nxt[XLEN-1:0];
        rem      = acc_nxt[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            final_res = op_q[1] ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);
        end else begin
            final_res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            neg_q      <= 1'b0;
            mb_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        out_tag <= in_tag;
                        neg_q   <= neg_d;
                        mb_q    <= mag_b;
                        acc_q   <= {{XLEN{1'b0}}, mag_a};
                        if (div_zero || div_ovf) begin
                            out_result <= special_res;
                            state_q    <= StDone;
                        end else begin
                            cnt_q   <= CW'(XLEN);
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        out_result <= final_res;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/rv_muldiv.md
# rv_muldiv

Parametrised iterative multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the EX-stage ALU of the RISC-V pipeline and accepts one operation at a time over a valid/ready handshake. It returns a tagged result that the pipeline holds its stages on until completion. Operand width is generic, and a flush input lets branch/jump redirects abort an in-flight operation.

## Interface
- XLEN, default 32: operand/result width; legal values are even and ≥ 4.
- TAG_W, default 5: width of the pass-through destination tag (rd address).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  input  XLEN  rs1 operand.
- in_b  input  XLEN  rs2 operand.
- in_tag  input  TAG_W  destination tag, returned unchanged.
- flush  input  1  abort the current operation and discard its result.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes the result.
- out_result  output  XLEN  result word.
- out_tag  output  TAG_W  tag of the returned result.

## Operation
- The unit has three states: IDLE, CALC and DONE.
- **Accept.** An operation is accepted on a rising edge where in_valid && in_ready && !flush. On that edge the unit latches op, tag and operand magnitudes, records the result sign, and moves to CALC with the iteration counter set to XLEN.
- **Signedness.**
  - MUL, MULH and DIV/REM treat both operands as signed.
  - MULHSU treats in_a as signed and in_b as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
  - Magnitudes are taken on accept; the 2's-complement result fix-up is applied on CALC→DONE.
- **Multiply.** Radix-2 shift-add over a 2·XLEN-bit product register, one bit per cycle.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2·XLEN-1:XLEN].
- **Divide.** Restoring division, one quotient bit per cycle.
  - DIV/DIVU return the quotient.
  - REM/REMU return the remainder.
  - The sign of the quotient is sign(a) XOR sign(b). The sign of the remainder is sign(a).
- **Special cases.** These bypass CALC: the accept edge goes directly to DONE.
  - Divide by zero (b = 0): quotient is all-ones, remainder is in_a.
  - Signed overflow (DIV/REM with a = −2^(XLEN−1), b = −1): quotient is in_a, remainder is 0.
  - Multiply has no special case.
- **Iteration.** CALC decrements the counter each cycle. The edge on which the counter reaches 0 writes the fixed-up result to out_result and enters DONE.
- **Completion.** In DONE, out_valid = 1, and out_result and out_tag are stable. The edge with out_ready = 1 returns the unit to IDLE.
- **Flush.** flush = 1 on any edge forces IDLE on that edge. out_valid and the pending result are discarded, and the counter clears. When flush and in_valid are high on the same edge, flush wins and nothing is accepted.
- **Out-of-range op.** No in_op value is illegal: all eight encodings are defined.

## Timing
- **Reset.** When rst_n goes low, the unit asynchronously goes to IDLE, with in_ready = 1, out_valid = 0, out_result = 0, out_tag = 0 and the counter cleared. This applies even if reset falls mid-operation; no result is ever produced for an operation interrupted by reset.
- **Normal latency.** The accepting edge is E0. out_valid is high in the cycle after edge E_XLEN, which is 32 cycles for XLEN = 32.
- **Special-case latency.** out_valid is high in the cycle after E0 (1 cycle).
- **Back-to-back issue.** in_ready goes high in the cycle after the out_valid && out_ready edge. The minimum issue interval is XLEN + 2 cycles.
- **Backpressure.** The DONE-state hold is unbounded; the outputs must not change while out_ready = 0.
- **Handshake rule.** in_ready never depends combinationally on in_valid. out_valid never depends combinationally on out_ready.

## Test plan
- **MUL timing.** MUL a=7, b=0xFFFFFFFD (−3), tag=5 → out_result 0xFFFFFFEB, out_tag 5; out_valid first high exactly 32 cycles after accept.
- **High-half multiplies.**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- **Division signs.**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7%2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
  - REMU 0xFFFFFFF9%2 → 1.
- **Special cases, each with 1-cycle latency.**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Backpressure.** Hold out_ready = 0 for 5 cycles after out_valid → out_result and out_tag are stable and in_ready = 0. Raise out_ready → in_ready = 1 on the next cycle, and a second op issued then completes correctly.
- **Flush and reset.**
  - Flush at cycle 10 of CALC → out_valid never rises and in_ready = 1 next cycle; a following MUL 3×4 → 12.
  - Deassert rst_n mid-CALC → all outputs immediately take their reset values.
  - Flush asserted with in_valid on the same edge → no accept.
